// File: rtl/data_cache_assoc.sv
// 2-way set-associative write-back/write-allocate data cache with 4-byte
// blocks, per-set LRU, and saturating hit/miss counters.
// Ports:
//   clk, reset (sync, active-low)
//   read/write/address/writedata -> readdata/busywait     (CPU side)
//   mem_read/mem_write/mem_address/mem_writedata          (memory requests)
//   mem_readdata/mem_busywait                             (memory response)
//   hit_count/miss_count                                  (statistics)
module data_cache_assoc #(
  parameter int ADDR_W   = 8,
  parameter int SET_BITS = 2,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [7:0]        writedata,
  output logic [7:0]        readdata,
  output logic              busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-3:0] mem_address,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_busywait,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int TAG_W = ADDR_W - SET_BITS - 2;
  localparam int NSETS = 1 << SET_BITS;

  typedef enum logic [1:0] {IDLE, WRITE_BACK, FETCH} state_e;

  state_e state_q, state_d;

  logic [1:0][NSETS-1:0] valid_q, dirty_q;
  logic [NSETS-1:0]      lru_q;
  logic [TAG_W-1:0]      tag_q  [2][NSETS];
  logic [31:0]           data_q [2][NSETS];

  logic victim_q, retry_q;
  logic mem_read_q, mem_read_d;
  logic mem_write_q, mem_write_d;
  logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q;

  logic [SET_BITS-1:0] set;
  logic [TAG_W-1:0]    tag;
  logic [1:0]          off;
  logic [1:0]          hit_w;
  logic                hit, hway, victim, need_wb;
  logic                access, miss_ev, hit_ev, fill;
  logic [31:0]         hblk;

  assign set = address[SET_BITS+1:2];
  assign tag = address[ADDR_W-1:SET_BITS+2];
  assign off = address[1:0];

  assign hit_w[0] = valid_q[0][set] && (tag_q[0][set] == tag);
  assign hit_w[1] = valid_q[1][set] && (tag_q[1][set] == tag);
  assign hit      = |hit_w;
  assign hway     = hit_w[1];

  // Fill empty ways first, otherwise replace the LRU way.
  assign victim  = !valid_q[0][set] ? 1'b0 :
                   !valid_q[1][set] ? 1'b1 : lru_q[set];
  assign need_wb = valid_q[victim][set] && dirty_q[victim][set];

  assign access  = read | write;
  assign miss_ev = (state_q == IDLE) && access && !hit;
  assign hit_ev  = (state_q == IDLE) && access && hit;
  assign fill    = (state_q == FETCH) && !mem_busywait;

  assign hblk     = data_q[hway][set];
  assign readdata = hblk[{off, 3'b000} +: 8];
  assign busywait = access && !((state_q == IDLE) && hit);

  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = mem_addr_q;
  assign mem_writedata = mem_wdata_q;
  assign hit_count     = hit_cnt_q;
  assign miss_count    = miss_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (miss_ev) state_d = need_wb ? WRITE_BACK : FETCH;
      WRITE_BACK: if (!mem_busywait) state_d = FETCH;
      FETCH:      if (!mem_busywait) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (miss_ev && need_wb) begin
          mem_write_d = 1'b1;
          mem_read_d  = 1'b0;
          mem_addr_d  = {tag_q[victim][set], set};
          mem_wdata_d = data_q[victim][set];
        end else if (miss_ev) begin
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
          mem_addr_d  = address[ADDR_W-1:2];
        end
      end
      WRITE_BACK: begin
        if (!mem_busywait) begin
          mem_write_d = 1'b0;
          mem_read_d  = 1'b1;
          mem_addr_d  = address[ADDR_W-1:2];
        end
      end
      FETCH: begin
        if (!mem_busywait) mem_read_d = 1'b0;
      end
      default: begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
      lru_q       <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      victim_q    <= 1'b0;
      retry_q     <= 1'b0;
    end else begin
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      // The first IDLE hit after a fill is the stalled access completing.
      retry_q     <= fill;
      if (miss_ev) begin
        victim_q <= victim;
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      end
      if (hit_ev) begin
        lru_q[set] <= ~hway;
        if (write) dirty_q[hway][set] <= 1'b1;
        if (!retry_q && hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
      end
      if (fill) begin
        valid_q[victim_q][set] <= 1'b1;
        dirty_q[victim_q][set] <= 1'b0;
        lru_q[set]             <= ~victim_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (hit_ev && write) data_q[hway][set][{off, 3'b000} +: 8] <= writedata;
    if (fill) begin
      data_q[victim_q][set] <= mem_readdata;
      tag_q[victim_q][set]  <= tag;
    end
  end

endmodule

// File: tb/tb_data_cache_assoc.sv
// Directed bench for data_cache_assoc: table of CPU accesses against a
// latency-configurable memory model, plus hand sequences for corners.
module tb_data_cache_assoc;

  logic        clk, rst;
  logic        rd, wr;
  logic [7:0]  addr, wdata, readdata;
  logic        busywait, mem_read, mem_write, mem_busywait;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata, mem_readdata;
  logic [15:0] hit_count, miss_count;

  logic        rd2, busy2, mr2, mw2;
  logic [7:0]  addr2, wdata2, readdata2;
  logic        wr2, mbw2;
  logic [5:0]  ma2;
  logic [31:0] mwd2, mrd2;
  logic [1:0]  hit2, miss2;

  data_cache_assoc dut (
    .clk(clk), .reset(rst), .read(rd), .write(wr),
    .address(addr), .writedata(wdata),
    .readdata(readdata), .busywait(busywait),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  data_cache_assoc #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(rst), .read(rd2), .write(wr2),
    .address(addr2), .writedata(wdata2),
    .readdata(readdata2), .busywait(busy2),
    .mem_read(mr2), .mem_write(mw2),
    .mem_address(ma2), .mem_writedata(mwd2),
    .mem_readdata(mrd2), .mem_busywait(mbw2),
    .hit_count(hit2), .miss_count(miss2)
  );

  int checks = 0;
  int errors = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", nm, act, exp);
    end
  endtask

  // Memory model: each request is held busy for 'lat' cycles.
  logic [31:0] mem [64];
  int          lat = 0;
  int          cnt = 0;
  int          nr = 0, nw = 0;
  logic [5:0]  last_ra = 0, last_wa = 0;
  logic [31:0] last_wd = 0;

  initial begin
    mem_busywait = 0;
    mem_readdata = 0;
    forever begin
      @(negedge clk);
      checks++;
      if (mem_read && mem_write) begin
        errors++;
        $display("FAIL rw_excl actual 11 required not both");
      end
      if (mem_read || mem_write) begin
        if (cnt < lat) begin
          mem_busywait = 1;
          cnt++;
        end else begin
          mem_busywait = 0;
          cnt = 0;
          if (mem_read) begin
            mem_readdata = mem[mem_address];
            nr++;
            last_ra = mem_address;
          end else begin
            mem[mem_address] = mem_writedata;
            nw++;
            last_wa = mem_address;
            last_wd = mem_writedata;
          end
        end
      end else begin
        mem_busywait = 0;
        cnt = 0;
      end
    end
  end

  task automatic access(input logic r, input logic w, input logic [7:0] a,
                        input logic [7:0] d, output logic [7:0] rdv,
                        output logic ok);
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d; ok = 0;
    for (int n = 0; n < 100; n++) begin
      #1;
      if (!busywait) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    rdv = readdata;
    @(posedge clk);
    #1;
    rd = 0; wr = 0;
  endtask

  typedef struct {
    logic        r, w;
    logic [7:0]  a, d;
    int          lat;
    logic [7:0]  erd;
    int          eh, em, enr, enw;
    logic [5:0]  era, ewa;
    logic [31:0] ewd;
  } vec_t;

  localparam int NV = 13;
  vec_t vt [NV];

  logic [7:0] rdv;
  logic       ok;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[6'h09] = 32'h44332211;
    mem[6'h19] = 32'h88776655;
    mem[6'h29] = 32'hCCBBAA99;
    mem[6'h39] = 32'h13579BDF;
    mem[6'h02] = 32'hDEADBEEF;
    mem[6'h10] = 32'h0BADF00D;
    mem[6'h20] = 32'h00C0FFEE;

    vt[0]  = '{1,0,8'h24,8'h00,0,8'h11,0,1,1,0,6'h09,6'h00,32'h0};
    vt[1]  = '{0,1,8'h26,8'hAB,0,8'h00,1,1,1,0,6'h09,6'h00,32'h0};
    vt[2]  = '{1,0,8'h26,8'h00,0,8'hAB,2,1,1,0,6'h09,6'h00,32'h0};
    vt[3]  = '{1,0,8'h64,8'h00,1,8'h55,2,2,2,0,6'h19,6'h00,32'h0};
    vt[4]  = '{1,0,8'hA4,8'h00,2,8'h99,2,3,3,1,6'h29,6'h09,32'h44AB2211};
    vt[5]  = '{1,0,8'h67,8'h00,0,8'h88,3,3,3,1,6'h29,6'h09,32'h44AB2211};
    vt[6]  = '{0,1,8'h65,8'h5A,0,8'h00,4,3,3,1,6'h29,6'h09,32'h44AB2211};
    vt[7]  = '{1,0,8'h24,8'h00,1,8'h11,4,4,4,1,6'h09,6'h09,32'h44AB2211};
    vt[8]  = '{1,0,8'h26,8'h00,0,8'hAB,5,4,4,1,6'h09,6'h09,32'h44AB2211};
    vt[9]  = '{1,0,8'hE4,8'h00,3,8'hDF,5,5,5,2,6'h39,6'h19,32'h88775A55};
    vt[10] = '{1,0,8'h08,8'h00,0,8'hEF,5,6,6,2,6'h02,6'h19,32'h88775A55};
    vt[11] = '{1,1,8'h0A,8'h77,0,8'h00,6,6,6,2,6'h02,6'h19,32'h88775A55};
    vt[12] = '{1,0,8'h0A,8'h00,0,8'h77,7,6,6,2,6'h02,6'h19,32'h88775A55};

    rst = 0; rd = 0; wr = 0; addr = 0; wdata = 0;
    rd2 = 0; wr2 = 0; addr2 = 0; wdata2 = 0; mbw2 = 0; mrd2 = 32'h12345678;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1;
    chk("rst_mem_read", 32'(mem_read), 0);
    chk("rst_mem_write", 32'(mem_write), 0);
    chk("rst_mem_addr", 32'(mem_address), 0);
    chk("rst_mem_wdata", mem_writedata, 0);
    chk("rst_hits", 32'(hit_count), 0);
    chk("rst_misses", 32'(miss_count), 0);
    chk("rst_busywait", 32'(busywait), 0);

    for (int i = 0; i < NV; i++) begin
      lat = vt[i].lat;
      access(vt[i].r, vt[i].w, vt[i].a, vt[i].d, rdv, ok);
      chk($sformatf("v%0d_done", i), 32'(ok), 1);
      if (vt[i].r && !vt[i].w)
        chk($sformatf("v%0d_rdata", i), 32'(rdv), 32'(vt[i].erd));
      chk($sformatf("v%0d_hits", i), 32'(hit_count), 32'(vt[i].eh));
      chk($sformatf("v%0d_misses", i), 32'(miss_count), 32'(vt[i].em));
      chk($sformatf("v%0d_nreads", i), 32'(nr), 32'(vt[i].enr));
      chk($sformatf("v%0d_nwrites", i), 32'(nw), 32'(vt[i].enw));
      chk($sformatf("v%0d_raddr", i), 32'(last_ra), 32'(vt[i].era));
      chk($sformatf("v%0d_waddr", i), 32'(last_wa), 32'(vt[i].ewa));
      chk($sformatf("v%0d_wdata", i), last_wd, vt[i].ewd);
    end

    // Memory stalls for 5 cycles during FETCH.
    lat = 5;
    @(negedge clk);
    rd = 1; addr = 8'h40;
    @(posedge clk); #1;
    chk("stall_req", {mem_read, mem_write, busywait}, 3'b101);
    chk("stall_addr", 32'(mem_address), 32'h10);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("stall_hold%0d", i),
          {mem_read, mem_write, busywait, mem_address}, {3'b101, 6'h10});
    end
    @(posedge clk); #1;
    chk("stall_release", {mem_read, mem_write, busywait}, 3'b000);
    chk("stall_rdata", 32'(readdata), 32'h0D);
    @(posedge clk); #1;
    rd = 0;
    chk("stall_hits", 32'(hit_count), 7);
    chk("stall_misses", 32'(miss_count), 7);

    // Make a dirty way 0 and a clean way 1 in set 0, then evict way 0.
    lat = 0;
    access(0, 1, 8'h41, 8'h3C, rdv, ok);
    access(1, 0, 8'h80, 8'h00, rdv, ok);
    chk("set0_fill_rdata", 32'(rdv), 32'hEE);
    lat = 5;
    @(negedge clk);
    rd = 1; addr = 8'hC0;
    @(posedge clk); #1;
    chk("wb_req", {mem_read, mem_write}, 2'b01);
    chk("wb_addr", 32'(mem_address), 32'h10);
    chk("wb_data", mem_writedata, 32'h0BAD3C0D);
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    chk("rstwb_req", {mem_read, mem_write}, 2'b00);
    chk("rstwb_hits", 32'(hit_count), 0);
    chk("rstwb_misses", 32'(miss_count), 0);
    chk("rstwb_addr", 32'(mem_address), 0);
    chk("rstwb_busy", 32'(busywait), 1);
    @(negedge clk);
    rst = 1; rd = 0;
    lat = 0;
    access(1, 0, 8'h24, 8'h00, rdv, ok);
    chk("reread_done", 32'(ok), 1);
    chk("reread_rdata", 32'(rdv), 32'h11);
    chk("reread_misses", 32'(miss_count), 1);
    chk("reread_hits", 32'(hit_count), 0);
    chk("reread_nwrites", 32'(nw), 2);

    // 2-bit counters saturate at 3 under back-to-back hits.
    @(negedge clk);
    rd2 = 1; addr2 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("sat_miss", 32'(miss2), 1);
    chk("sat_hit0", 32'(hit2), 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("sat_hit%0d", i + 1), 32'(hit2), (i < 3) ? i + 1 : 3);
    end
    rd2 = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
